// File: rtl/adxl345_burst_reader.sv
// SPI mode-3 master for the ADXL345: one POWER_CTL write after reset, then
// periodic 6-byte burst reads of DATAX0..DATAZ1 presented as a strobed byte stream.
module adxl345_burst_reader #(
    parameter int         CLK_DIV    = 25,
    parameter int         SAMPLE_GAP = 50000,
    parameter logic [7:0] INIT_ADDR  = 8'h2D,
    parameter logic [7:0] INIT_DATA  = 8'h08
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       pause_i,
    input  logic       spi_miso_i,
    output logic       spi_cs_no,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    output logic [7:0] data_o,
    output logic       enable_o,
    output logic       frame_done_o,
    output logic       busy_o,
    output logic       init_done_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (SAMPLE_GAP > 1) ? $clog2(SAMPLE_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SAMPLE_GAP - 1);

    // tick_cnt_reg values on the tick that ends each phase
    localparam logic [6:0] WR_CS_TICK   = 7'd32;   // 16 bits * 2 SCLK edges
    localparam logic [6:0] CMD_END_TICK = 7'd15;   // 8th rising edge of the command
    localparam logic [6:0] RD_CS_TICK   = 7'd112;  // 56 bits * 2 SCLK edges
    localparam logic [6:0] LAST_RISE    = 7'd112;  // tick_next of the 56th rising edge
    localparam logic [6:0] GAP_END_TICK = 7'd1;    // two ticks of CS-high time
    localparam logic [7:0] RD_CMD_BYTE  = 8'hF2;

    typedef enum logic [2:0] {
        INIT_WR,
        INIT_GAP,
        IDLE,
        RD_CMD,
        RD_DATA,
        HOLD
    } state_t;

    state_t           state_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [6:0]       tick_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic [15:0]      tx_shift_reg;
    logic [7:0]       rx_shift_reg;
    logic             cs_reg;
    logic             sclk_reg;
    logic             mosi_reg;
    logic [7:0]       data_reg;
    logic             enable_reg;
    logic             frame_done_reg;
    logic             busy_reg;
    logic             init_done_reg;
    logic             byte_pend_reg;
    logic             last_pend_reg;

    logic       tick;
    logic [6:0] tick_next;
    logic [6:0] cs_tick;
    logic       shifting;
    logic       byte_done;

    assign tick      = (div_cnt_reg == DIV_MAX);
    assign tick_next = tick_cnt_reg + 7'd1;
    assign cs_tick   = (state_reg == INIT_WR) ? WR_CS_TICK : RD_CS_TICK;
    // SCLK only toggles while CS is low and the CS-release tick has not come
    assign shifting  = !cs_reg && tick && (tick_cnt_reg != cs_tick);
    assign byte_done = shifting && !sclk_reg && (state_reg == RD_DATA)
                       && (tick_next[3:0] == 4'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg      <= INIT_WR;
            div_cnt_reg    <= '0;
            tick_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            tx_shift_reg   <= '0;
            rx_shift_reg   <= '0;
            cs_reg         <= 1'b1;
            sclk_reg       <= 1'b1;
            mosi_reg       <= 1'b0;
            data_reg       <= '0;
            enable_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
            init_done_reg  <= 1'b0;
            byte_pend_reg  <= 1'b0;
            last_pend_reg  <= 1'b0;
        end else begin
            enable_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            div_cnt_reg    <= tick ? '0 : div_cnt_reg + DIV_W'(1);
            if (gap_cnt_reg != GAP_MAX) begin
                gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
            end

            // byte completed on the previous edge is published one clock later
            if (byte_pend_reg) begin
                data_reg       <= rx_shift_reg;
                enable_reg     <= 1'b1;
                frame_done_reg <= last_pend_reg;
                byte_pend_reg  <= 1'b0;
            end

            if (shifting) begin
                sclk_reg <= ~sclk_reg;
                if (sclk_reg) begin
                    mosi_reg     <= tx_shift_reg[15];
                    tx_shift_reg <= {tx_shift_reg[14:0], 1'b0};
                end else begin
                    rx_shift_reg <= {rx_shift_reg[6:0], spi_miso_i};
                end
            end
            if (byte_done) begin
                byte_pend_reg <= 1'b1;
                last_pend_reg <= (tick_next == LAST_RISE);
            end

            case (state_reg)
                INIT_WR: begin
                    if (cs_reg) begin
                        cs_reg       <= 1'b0;
                        busy_reg     <= 1'b1;
                        div_cnt_reg  <= '0;
                        tick_cnt_reg <= '0;
                        tx_shift_reg <= {2'b00, INIT_ADDR[5:0], INIT_DATA};
                    end else if (tick) begin
                        tick_cnt_reg <= tick_next;
                        if (tick_cnt_reg == WR_CS_TICK) begin
                            cs_reg       <= 1'b1;
                            mosi_reg     <= 1'b0;
                            tick_cnt_reg <= '0;
                            state_reg    <= INIT_GAP;
                        end
                    end
                end
                INIT_GAP: begin
                    if (tick) begin
                        tick_cnt_reg <= tick_next;
                        if (tick_cnt_reg == GAP_END_TICK) begin
                            busy_reg      <= 1'b0;
                            init_done_reg <= 1'b1;
                            gap_cnt_reg   <= GAP_MAX;  // first burst needs no gap
                            state_reg     <= IDLE;
                        end
                    end
                end
                IDLE: begin
                    if (gap_cnt_reg == GAP_MAX && !pause_i) begin
                        cs_reg       <= 1'b0;
                        busy_reg     <= 1'b1;
                        div_cnt_reg  <= '0;
                        tick_cnt_reg <= '0;
                        tx_shift_reg <= {RD_CMD_BYTE, 8'h00};
                        state_reg    <= RD_CMD;
                    end
                end
                RD_CMD: begin
                    if (tick) begin
                        tick_cnt_reg <= tick_next;
                        if (tick_cnt_reg == CMD_END_TICK) begin
                            state_reg <= RD_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (tick) begin
                        tick_cnt_reg <= tick_next;
                        if (tick_cnt_reg == RD_CS_TICK) begin
                            cs_reg       <= 1'b1;
                            mosi_reg     <= 1'b0;
                            tick_cnt_reg <= '0;
                            gap_cnt_reg  <= '0;
                            state_reg    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        tick_cnt_reg <= tick_next;
                        if (tick_cnt_reg == GAP_END_TICK) begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= INIT_WR;
            endcase
        end
    end

    assign spi_cs_no    = cs_reg;
    assign spi_sclk_o   = sclk_reg;
    assign spi_mosi_o   = mosi_reg;
    assign data_o       = data_reg;
    assign enable_o     = enable_reg;
    assign frame_done_o = frame_done_reg;
    assign busy_o       = busy_reg;
    assign init_done_o  = init_done_reg;

endmodule

// File: tb/tb_adxl345_burst_reader.sv
// Bench for adxl345_burst_reader: mode-3 slave model with random data,
// timing expectations derived from CLK_DIV / SAMPLE_GAP arithmetic.
module tb_adxl345_burst_reader;

    localparam int CD  = 2;
    localparam int GAP = 20;

    typedef struct {
        int          rises;
        logic [63:0] bits;
    } txn_t;

    typedef struct {
        int         cyc;
        logic       fd;
        logic [7:0] d;
    } strobe_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pause = 1'b0;
    logic       miso = 1'b0;
    logic       spi_cs_no, spi_sclk_o, spi_mosi_o;
    logic [7:0] data_o;
    logic       enable_o, frame_done_o, busy_o, init_done_o;

    adxl345_burst_reader #(
        .CLK_DIV   (CD),
        .SAMPLE_GAP(GAP),
        .INIT_ADDR (8'h2D),
        .INIT_DATA (8'h08)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .pause_i     (pause),
        .spi_miso_i  (miso),
        .spi_cs_no   (spi_cs_no),
        .spi_sclk_o  (spi_sclk_o),
        .spi_mosi_o  (spi_mosi_o),
        .data_o      (data_o),
        .enable_o    (enable_o),
        .frame_done_o(frame_done_o),
        .busy_o      (busy_o),
        .init_done_o (init_done_o)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          proto_err = 0;
    int          last_fall = 0, last_rise = 0, fall_cnt = 0, init_rise = 0;
    logic [7:0]  resp [6];
    txn_t        txn_q[$];
    strobe_t     strobe_q[$];
    int          rcnt = 0, fcnt = 0;
    logic [63:0] mbits = '0;
    logic        mosi_half = 1'b0;

    task automatic check_value(input string tag, input int got, input int exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor sampled on the inactive edge
    initial begin
        logic cs_prev, init_prev;
        cs_prev = 1'b1;
        init_prev = 1'b0;
        forever begin
            @(negedge clk);
            mosi_half = spi_mosi_o;
            if (cs_prev === 1'b1 && spi_cs_no === 1'b0) begin
                last_fall = cyc;
                fall_cnt++;
            end
            if (cs_prev === 1'b0 && spi_cs_no === 1'b1) last_rise = cyc;
            cs_prev = spi_cs_no;
            if (!init_prev && init_done_o === 1'b1) init_rise = cyc;
            init_prev = (init_done_o === 1'b1);
            if (enable_o === 1'b1) strobe_q.push_back('{cyc, frame_done_o, data_o});
            if (frame_done_o === 1'b1 && enable_o !== 1'b1) proto_err++;
            if (rst_n === 1'b1 && spi_cs_no === 1'b1 && spi_sclk_o !== 1'b1) proto_err++;
        end
    end

    // Mode-3 slave: shifts MOSI in on rising SCLK, drives MISO on falling SCLK
    initial forever begin
        @(negedge spi_cs_no);
        rcnt = 0;
        fcnt = 0;
        mbits = '0;
    end

    initial forever begin
        @(posedge spi_sclk_o);
        if (spi_cs_no === 1'b0 && rst_n === 1'b1) begin
            if (spi_mosi_o !== mosi_half) proto_err++;
            mbits = {mbits[62:0], spi_mosi_o};
            rcnt++;
        end
    end

    initial forever begin
        @(negedge spi_sclk_o);
        if (spi_cs_no === 1'b0 && rst_n === 1'b1) begin
            logic [7:0] b;
            b = 8'h00;
            if (fcnt >= 8 && fcnt < 56) begin
                b = resp[(fcnt - 8) / 8];
                miso = b[7 - ((fcnt - 8) % 8)];
            end else begin
                miso = 1'b0;
            end
            fcnt++;
        end
    end

    initial forever begin
        @(posedge spi_cs_no);
        if (rst_n === 1'b1) txn_q.push_back('{rcnt, mbits});
    end

    task automatic wait_txn(input string tag, input logic pause_mid, output txn_t t);
        int n;
        n = 0;
        t.rises = 0;
        t.bits = '0;
        while (txn_q.size() == 0 && n < 1000) begin
            @(negedge clk);
            n++;
            if (pause_mid && strobe_q.size() >= 2) pause = 1'b1;
        end
        if (txn_q.size() == 0) check_value({tag, "_timeout"}, 0, 1);
        else t = txn_q.pop_front();
    endtask

    task automatic check_init(input string tag);
        txn_t t;
        int   n;
        wait_txn(tag, 1'b0, t);
        $display("%s: write rises=%0d mosi=0x%04h", tag, t.rises, t.bits[15:0]);
        check_value({tag, "_rises"}, t.rises, 16);
        check_value({tag, "_mosi"}, int'(t.bits[15:0]), 32'h2D08);
        n = 0;
        while (init_done_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_value({tag, "_done"}, int'(init_done_o), 1);
        check_value({tag, "_done_delay"}, init_rise - last_rise, 2 * CD);
        check_value({tag, "_busy_low"}, int'(busy_o), 0);
        strobe_q.delete();
    endtask

    task automatic check_burst(input string tag, input logic pause_mid);
        txn_t t;
        wait_txn(tag, pause_mid, t);
        $display("%s: read rises=%0d cmd=0x%02h strobes=%0d exp=%02h %02h %02h %02h %02h %02h",
                 tag, t.rises, t.bits[55:48], strobe_q.size(),
                 resp[0], resp[1], resp[2], resp[3], resp[4], resp[5]);
        check_value({tag, "_rises"}, t.rises, 56);
        check_value({tag, "_cmd"}, int'(t.bits[55:48]), 32'hF2);
        check_value({tag, "_mosi_zero"}, int'(t.bits[47:0] != 48'd0), 0);
        check_value({tag, "_nstrobe"}, strobe_q.size(), 6);
        for (int i = 0; i < 6 && i < strobe_q.size(); i++) begin
            check_value($sformatf("%s_byte%0d", tag, i), int'(strobe_q[i].d), int'(resp[i]));
            check_value($sformatf("%s_fd%0d", tag, i), int'(strobe_q[i].fd), (i == 5) ? 1 : 0);
            if (i > 0)
                check_value($sformatf("%s_space%0d", tag, i),
                            strobe_q[i].cyc - strobe_q[i-1].cyc, 16 * CD);
        end
        if (strobe_q.size() > 0)
            check_value({tag, "_first"}, strobe_q[0].cyc - last_fall, 32 * CD + 1);
        strobe_q.delete();
    endtask

    task automatic rand_resp();
        for (int i = 0; i < 6; i++) resp[i] = 8'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int prev_rise, fc, p;
        rst_n = 1'b0;
        resp[0] = 8'h00; resp[1] = 8'h00; resp[2] = 8'h10;
        resp[3] = 8'h01; resp[4] = 8'h20; resp[5] = 8'h30;
        repeat (3) @(negedge clk);
        check_value("rst_cs", int'(spi_cs_no), 1);
        check_value("rst_sclk", int'(spi_sclk_o), 1);
        check_value("rst_mosi", int'(spi_mosi_o), 0);
        check_value("rst_data", int'(data_o), 0);
        check_value("rst_en", int'(enable_o), 0);
        check_value("rst_fd", int'(frame_done_o), 0);
        check_value("rst_busy", int'(busy_o), 0);
        check_value("rst_init", int'(init_done_o), 0);
        rst_n = 1'b1;

        check_init("init");
        check_burst("burst1", 1'b0);
        check_value("burst1_nogap", last_fall - init_rise, 1);

        resp[0] = 8'hC0; resp[1] = 8'h03; resp[2] = 8'hD0;
        resp[3] = 8'h03; resp[4] = 8'h20; resp[5] = 8'h30;
        prev_rise = last_rise;
        check_burst("burst2", 1'b0);
        check_value("burst2_gap", last_fall - prev_rise, GAP);

        for (int r = 0; r < 3; r++) begin
            rand_resp();
            prev_rise = last_rise;
            check_burst($sformatf("rand%0d", r), (r == 2));
            check_value($sformatf("rand%0d_gap", r), last_fall - prev_rise, GAP);
        end

        // pause held across gap expiry
        fc = fall_cnt;
        repeat (GAP + 100) @(negedge clk);
        check_value("pause_nofall", fall_cnt, fc);
        check_value("pause_nostrobe", strobe_q.size(), 0);
        check_value("pause_cs", int'(spi_cs_no), 1);
        rand_resp();
        p = cyc;
        pause = 1'b0;
        check_burst("unpause", 1'b0);
        check_value("unpause_start", last_fall - p, 1);

        // reset after third strobe of a burst
        rand_resp();
        p = 0;
        while (strobe_q.size() < 3 && p < 1000) begin
            @(negedge clk);
            p++;
        end
        check_value("abort_3strobes", strobe_q.size(), 3);
        #2 rst_n = 1'b0;
        #1;
        check_value("abort_cs", int'(spi_cs_no), 1);
        check_value("abort_sclk", int'(spi_sclk_o), 1);
        for (int i = 0; i < 3 && i < strobe_q.size(); i++)
            check_value($sformatf("abort_byte%0d", i), int'(strobe_q[i].d), int'(resp[i]));
        repeat (40) @(negedge clk);
        check_value("abort_nomore", strobe_q.size(), 3);
        check_value("abort_notxn", txn_q.size(), 0);
        $display("abort: reset asserted mid-burst, strobes=%0d", strobe_q.size());
        strobe_q.delete();
        rand_resp();
        rst_n = 1'b1;
        check_init("reinit");
        check_burst("post", 1'b0);

        check_value("protocol", proto_err, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
